// File: rtl/timer_capture.sv
// Input-capture unit: synchronizes an async event line, timestamps selected edges
// into a first-word-fall-through FIFO. Define TIMER_CAPTURE_DELTA_EN to store deltas.
module timer_capture #(
  parameter int CNT_W       = 4,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CNT_W-1:0]         count_i,
  input  logic                     event_i,
  input  logic [1:0]               edge_sel_i,
  output logic [CNT_W-1:0]         ts_o,
  output logic                     ts_valid_o,
  input  logic                     ts_ready_i,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     overflow_o,
  input  logic                     overflow_clr_i
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic [CNT_W-1:0]       r_mem [DEPTH];
  logic [AW-1:0]          r_wr_ptr;
  logic [AW-1:0]          r_rd_ptr;
  logic [LW-1:0]          r_level;
  logic                   r_overflow;

  logic                   w_s;
  logic                   w_rise;
  logic                   w_fall;
  logic                   w_det;
  logic                   w_nonempty;
  logic                   w_full;
  logic                   w_pop;
  logic                   w_push;
  logic                   w_drop;
  logic [CNT_W-1:0]       w_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], event_i};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_s    = r_sync[SYNC_STAGES-1];
  assign w_rise = w_s & ~r_prev;
  assign w_fall = ~w_s & r_prev;
  assign w_det  = (edge_sel_i[0] & w_rise) | (edge_sel_i[1] & w_fall);

`ifdef TIMER_CAPTURE_DELTA_EN
  // last_cap follows every detected event, even dropped ones, so deltas stay true
  logic [CNT_W-1:0] r_last_cap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_cap <= '0;
    end else if (w_det) begin
      r_last_cap <= count_i;
    end
  end

  assign w_wdata = count_i - r_last_cap;
`else
  assign w_wdata = count_i;
`endif

  assign w_nonempty = (r_level != '0);
  assign w_full     = (r_level == LW'(DEPTH));
  assign w_pop      = w_nonempty & ts_ready_i;
  assign w_push     = w_det & (~w_full | w_pop);
  assign w_drop     = w_det & w_full & ~w_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= w_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // A drop in the same cycle as a clear keeps the flag set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (overflow_clr_i) begin
      r_overflow <= 1'b0;
    end
  end

  assign ts_valid_o = w_nonempty;
  assign ts_o       = w_nonempty ? r_mem[r_rd_ptr] : '0;
  assign level_o    = r_level;
  assign overflow_o = r_overflow;

endmodule

// File: tb/tb_timer_capture.sv
// Randomized self-checking bench for timer_capture with a queue-based reference model.
// Build with TIMER_CAPTURE_DELTA_EN defined to exercise delta mode.
`timescale 1ns/1ps
module tb_timer_capture;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] count_i;
  logic       event_i;
  logic [1:0] edge_sel_i;
  logic [3:0] ts_o;
  logic       ts_valid_o;
  logic       ts_ready_i;
  logic [2:0] level_o;
  logic       overflow_o;
  logic       overflow_clr_i;

  int n_total = 0;
  int n_pass  = 0;

  timer_capture #(.CNT_W(4), .DEPTH(4), .SYNC_STAGES(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .count_i        (count_i),
    .event_i        (event_i),
    .edge_sel_i     (edge_sel_i),
    .ts_o           (ts_o),
    .ts_valid_o     (ts_valid_o),
    .ts_ready_i     (ts_ready_i),
    .level_o        (level_o),
    .overflow_o     (overflow_o),
    .overflow_clr_i (overflow_clr_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
  endtask

  // Reference model: samples of event_i seen at past edges (index 0 = newest),
  // timestamps held in a plain queue of at most 4 entries.
  int         m_q[$];
  bit         m_ev[$];
  bit         m_ovf;
  logic [3:0] m_last;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_ev = '{1'b0, 1'b0, 1'b0};
      m_ovf = 1'b0;
      m_last = 4'd0;
    end else begin
      bit s, p, det, pop, drop;
      int val;
      s = m_ev[1];
      p = m_ev[2];
      det = (edge_sel_i[0] && s && !p) || (edge_sel_i[1] && !s && p);
      pop = (m_q.size() > 0) && ts_ready_i;
`ifdef TIMER_CAPTURE_DELTA_EN
      val = (int'(count_i) - int'(m_last)) & 15;
`else
      val = int'(count_i);
`endif
      if (det) m_last = count_i;
      if (pop) void'(m_q.pop_front());
      drop = det && (m_q.size() == 4);
      if (det && !drop) m_q.push_back(val);
      if (drop) m_ovf = 1'b1;
      else if (overflow_clr_i) m_ovf = 1'b0;
      m_ev.push_front(event_i);
      void'(m_ev.pop_back());
    end
  end

  always @(negedge clk) begin
    chk("valid", int'(ts_valid_o), (m_q.size() > 0) ? 1 : 0);
    chk("ts", int'(ts_o), (m_q.size() > 0) ? m_q[0] : 0);
    chk("level", int'(level_o), m_q.size());
    chk("overflow", int'(overflow_o), int'(m_ovf));
  end

  task automatic step();
    @(posedge clk);
    #1;
    count_i = count_i + 4'd1;
  endtask

  task automatic wait_cnt(input logic [3:0] c);
    for (int n = 0; n < 40 && count_i != c; n++) step();
    chk("wait_cnt", int'(count_i), int'(c));
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic pop1();
    ts_ready_i = 1'b1;
    step();
    ts_ready_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    count_i = 4'd0;
    event_i = 1'b0;
    edge_sel_i = 2'b01;
    ts_ready_i = 1'b0;
    overflow_clr_i = 1'b0;
    #1;
    chk("rst_valid", int'(ts_valid_o), 0);
    chk("rst_ts", int'(ts_o), 0);
    chk("rst_level", int'(level_o), 0);
    chk("rst_ovf", int'(overflow_o), 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

`ifndef TIMER_CAPTURE_DELTA_EN
    // Rising capture: event high in count 3 -> detect in count 5
    wait_cnt(4'd3);
    event_i = 1'b1;
    wait_cnt(4'd6);
    settle();
    chk("t1_valid", int'(ts_valid_o), 1);
    chk("t1_ts", int'(ts_o), 5);
    chk("t1_level", int'(level_o), 1);
    event_i = 1'b0;
    repeat (5) step();
    settle();
    chk("t1_fall_ignored", int'(level_o), 1);
    pop1();
    settle();
    chk("t1_empty", int'(level_o), 0);

    // Both edges across count wrap
    edge_sel_i = 2'b11;
    wait_cnt(4'd13);
    event_i = 1'b1;
    wait_cnt(4'd1);
    event_i = 1'b0;
    wait_cnt(4'd5);
    settle();
    chk("t2_level", int'(level_o), 2);
    chk("t2_ts0", int'(ts_o), 15);
    pop1();
    settle();
    chk("t2_ts1", int'(ts_o), 3);
    pop1();
    settle();
    chk("t2_empty", int'(ts_valid_o), 0);
`endif

    // Overflow with five edges into a 4-deep FIFO
    edge_sel_i = 2'b11;
    ts_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      event_i = ~event_i;
      repeat (4) step();
    end
    settle();
    chk("t3_level", int'(level_o), 4);
    chk("t3_ovf", int'(overflow_o), 1);
    overflow_clr_i = 1'b1;
    step();
    overflow_clr_i = 1'b0;
    settle();
    chk("t3_clr", int'(overflow_o), 0);
    event_i = ~event_i;
    step();
    step();
    overflow_clr_i = 1'b1;
    step();
    overflow_clr_i = 1'b0;
    settle();
    chk("t3_drop_wins", int'(overflow_o), 1);

    // Full FIFO: push and pop in the same cycle
    overflow_clr_i = 1'b1;
    step();
    overflow_clr_i = 1'b0;
    event_i = ~event_i;
    step();
    step();
    ts_ready_i = 1'b1;
    step();
    ts_ready_i = 1'b0;
    settle();
    chk("t4_level", int'(level_o), 4);
    chk("t4_ovf", int'(overflow_o), 0);

    // Asynchronous reset mid-stream
    pop1();
    settle();
    chk("t5_level3", int'(level_o), 3);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_valid", int'(ts_valid_o), 0);
    chk("t5_ts", int'(ts_o), 0);
    chk("t5_level", int'(level_o), 0);
    chk("t5_ovf", int'(overflow_o), 0);
    step();
    rst = 1'b0;
    event_i = 1'b0;
    edge_sel_i = 2'b00;
    for (int i = 0; i < 6; i++) begin
      event_i = ~event_i;
      repeat (3) step();
    end
    settle();
    chk("t5_sel_off", int'(level_o), 0);

`ifdef TIMER_CAPTURE_DELTA_EN
    // Rising edges detected at counts 5, 9, 2 -> deltas 5, 4, 9
    edge_sel_i = 2'b01;
    wait_cnt(4'd3);
    event_i = 1'b1;
    wait_cnt(4'd5);
    event_i = 1'b0;
    wait_cnt(4'd7);
    event_i = 1'b1;
    wait_cnt(4'd9);
    event_i = 1'b0;
    wait_cnt(4'd0);
    event_i = 1'b1;
    wait_cnt(4'd4);
    event_i = 1'b0;
    settle();
    chk("d_level", int'(level_o), 3);
    chk("d_ts0", int'(ts_o), 5);
    pop1();
    settle();
    chk("d_ts1", int'(ts_o), 4);
    pop1();
    settle();
    chk("d_ts2", int'(ts_o), 9);
    pop1();
`endif

    // Randomized phase
    edge_sel_i = 2'b11;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(3) == 0) event_i = ~event_i;
      ts_ready_i = ($urandom_range(2) == 0);
      overflow_clr_i = ($urandom_range(15) == 0);
      if ($urandom_range(31) == 0) edge_sel_i = 2'($urandom_range(3));
      if ($urandom_range(999) == 0) rst = 1'b1;
      step();
      rst = 1'b0;
    end
    ts_ready_i = 1'b1;
    repeat (8) step();
    settle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
